// File: rtl/lab02_pkg.sv
// Shared constants and types for the lab02 ALU and its two-requester arbiter.
package lab02_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    // ALU opcodes; anything above A_LAST is rejected by the arbiter
    localparam logic [OP_W-1:0] A_NOP  = 5'h00;
    localparam logic [OP_W-1:0] A_ADD  = 5'h01;
    localparam logic [OP_W-1:0] A_SUB  = 5'h02;
    localparam logic [OP_W-1:0] A_AND  = 5'h03;
    localparam logic [OP_W-1:0] A_OR   = 5'h04;
    localparam logic [OP_W-1:0] A_XOR  = 5'h05;
    localparam logic [OP_W-1:0] A_NOR  = 5'h06;
    localparam logic [OP_W-1:0] A_LAST = 5'h06;

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // One accepted operation, as latched at grant time
    typedef struct packed {
        logic              id;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= A_LAST);
    endfunction

    function automatic logic op_is_arith(input logic [OP_W-1:0] op);
        return (op == A_ADD) || (op == A_SUB);
    endfunction

endpackage

// File: rtl/lab02_alu.sv
// Combinational lab02 ALU. The sign output is bit 32 of the sign-extended
// 33-bit sum/difference, so it reports the true sign even on 32-bit overflow.
module lab02_alu
    import lab02_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] res_o,
    output logic              sign_o
);

    logic [DATA_W:0] a_ext;
    logic [DATA_W:0] b_ext;
    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;

    assign a_ext    = {a_i[DATA_W-1], a_i};
    assign b_ext    = {b_i[DATA_W-1], b_i};
    assign sum_ext  = a_ext + b_ext;
    assign diff_ext = a_ext - b_ext;

    // Opcode decode; NOP and undefined opcodes yield zero
    always_comb begin
        res_o  = '0;
        sign_o = 1'b0;
        case (op_i)
            A_ADD: begin
                res_o  = sum_ext[DATA_W-1:0];
                sign_o = sum_ext[DATA_W];
            end
            A_SUB: begin
                res_o  = diff_ext[DATA_W-1:0];
                sign_o = diff_ext[DATA_W];
            end
            A_AND:   res_o = a_i & b_i;
            A_OR:    res_o = a_i | b_i;
            A_XOR:   res_o = a_i ^ b_i;
            A_NOR:   res_o = ~(a_i | b_i);
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/lab02_alu_arb.sv
// Two-requester round-robin front end for a single shared lab02_alu.
// One operation is in flight at a time: IDLE grants, EXEC holds operands on
// the ALU for EXEC_CYCLES cycles, RESP presents the result until accepted.
module lab02_alu_arb
    import lab02_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter logic        START_PRI   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              req1_ready,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_sign,
    output logic              rsp_err
);

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic              pri_q, pri_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;

    logic              gnt_valid;
    logic              gnt_id;
    req_t              gnt_req;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_res;
    logic              alu_sign;

    // Grant selection: a lone valid wins, a tie goes to the priority pointer
    always_comb begin
        gnt_valid = (state_q == S_IDLE) && (req0_valid || req1_valid);
        gnt_id    = (req0_valid && req1_valid) ? pri_q : req1_valid;
        gnt_req   = gnt_id ? '{id: 1'b1, op: req1_op, a: req1_a, b: req1_b}
                           : '{id: 1'b0, op: req0_op, a: req0_a, b: req0_b};
    end

    assign req0_ready = gnt_valid && !gnt_id;
    assign req1_ready = gnt_valid &&  gnt_id;

    // The ALU only sees a real opcode while executing
    assign alu_a  = req_q.a;
    assign alu_b  = req_q.b;
    assign alu_op = (state_q == S_EXEC) ? req_q.op : A_NOP;

    lab02_alu u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .op_i   (alu_op),
        .res_o  (alu_res),
        .sign_o (alu_sign)
    );

    // Sequencer next-state: grant, execute window, response hold
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        sign_d  = sign_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    req_d = gnt_req;
                    pri_d = ~gnt_id;
                    cnt_d = '0;
                    if (op_legal(gnt_req.op)) begin
                        err_d   = 1'b0;
                        state_d = S_EXEC;
                    end else begin
                        // Illegal opcodes skip the ALU entirely
                        err_d   = 1'b1;
                        data_d  = '0;
                        sign_d  = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    data_d  = (req_q.op == A_NOP) ? '0 : alu_res;
                    sign_d  = op_is_arith(req_q.op) ? alu_sign : 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pointer, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pri_q   <= START_PRI;
            cnt_q   <= '0;
            req_q   <= '0;
            data_q  <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = req_q.id;
    assign rsp_data  = data_q;
    assign rsp_sign  = sign_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lab02_alu_arb.sv
// Scoreboard bench for lab02_alu_arb. Instance A (EXEC_CYCLES=1,
// START_PRI=0) is checked through an expected-response queue; instance B
// (EXEC_CYCLES=4, START_PRI=1) covers priority start and mid-EXEC reset.
module tb_lab02_alu_arb;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Instance A signals
    logic        a_rst_n;
    logic        a_req0_valid, a_req1_valid;
    logic [31:0] a_req0_a, a_req0_b, a_req1_a, a_req1_b;
    logic [4:0]  a_req0_op, a_req1_op;
    logic        a_req0_ready, a_req1_ready;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_id, a_rsp_sign, a_rsp_err;
    logic [31:0] a_rsp_data;

    // Instance B signals
    logic        b_rst_n;
    logic        b_req0_valid, b_req1_valid;
    logic [31:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
    logic [4:0]  b_req0_op, b_req1_op;
    logic        b_req0_ready, b_req1_ready;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_sign, b_rsp_err;
    logic [31:0] b_rsp_data;

    // Expected responses for instance A: {id, err, sign, data}
    logic [34:0] sb[$];

    lab02_alu_arb #(.EXEC_CYCLES(1), .START_PRI(1'b0)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .req0_valid(a_req0_valid), .req0_a(a_req0_a), .req0_b(a_req0_b),
        .req0_op(a_req0_op), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_a(a_req1_a), .req1_b(a_req1_b),
        .req1_op(a_req1_op), .req1_ready(a_req1_ready),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
        .rsp_data(a_rsp_data), .rsp_sign(a_rsp_sign), .rsp_err(a_rsp_err)
    );

    lab02_alu_arb #(.EXEC_CYCLES(4), .START_PRI(1'b1)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_req0_valid), .req0_a(b_req0_a), .req0_b(b_req0_b),
        .req0_op(b_req0_op), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_a(b_req1_a), .req1_b(b_req1_b),
        .req1_op(b_req1_op), .req1_ready(b_req1_ready),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_data(b_rsp_data), .rsp_sign(b_rsp_sign), .rsp_err(b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one operation
    function automatic logic [34:0] model(input logic id, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] op);
        logic [32:0] s;
        logic [31:0] d;
        logic        sg;
        logic        er;
        d  = 32'h0;
        sg = 1'b0;
        er = 1'b0;
        case (op)
            5'h00: d = 32'h0;
            5'h01: begin s = {a[31], a} + {b[31], b}; d = s[31:0]; sg = s[32]; end
            5'h02: begin s = {a[31], a} - {b[31], b}; d = s[31:0]; sg = s[32]; end
            5'h03: d = a & b;
            5'h04: d = a | b;
            5'h05: d = a ^ b;
            5'h06: d = ~(a | b);
            default: er = 1'b1;
        endcase
        return {id, er, sg, d};
    endfunction

    // Response monitor for instance A: pop and compare on each handshake
    always @(negedge clk) begin
        if (a_rst_n && a_rsp_valid && a_rsp_ready) begin
            $display("[TB] A rsp id=%0d data=0x%08h sign=%0d err=%0d",
                     a_rsp_id, a_rsp_data, a_rsp_sign, a_rsp_err);
            if (sb.size() == 0) chk("a_sb_empty", 64'd1, 64'd0);
            else chk("a_rsp", {29'd0, a_rsp_id, a_rsp_err, a_rsp_sign, a_rsp_data},
                     {29'd0, sb.pop_front()});
        end
    end

    task automatic wait_gnt_a(output logic gid);
        int n = 0;
        @(negedge clk);
        while (!(a_req0_ready || a_req1_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("a_gnt_timeout", 64'd0, 64'd1);
        gid = a_req1_ready;
    endtask

    task automatic wait_gnt_b(output logic gid);
        int n = 0;
        @(negedge clk);
        while (!(b_req0_ready || b_req1_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("b_gnt_timeout", 64'd0, 64'd1);
        gid = b_req1_ready;
    endtask

    // Counts negedges from the cycle after the grant until rsp_valid
    task automatic lat_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_rsp_valid && n < 40);
    endtask

    task automatic lat_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_rsp_valid && n < 40);
    endtask

    task automatic single_a(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] op, input int lat);
        logic g;
        int   n;
        sb.push_back(model(id, a, b, op));
        if (id) begin
            a_req1_a = a; a_req1_b = b; a_req1_op = op; a_req1_valid = 1'b1;
        end else begin
            a_req0_a = a; a_req0_b = b; a_req0_op = op; a_req0_valid = 1'b1;
        end
        wait_gnt_a(g);
        chk("a_gnt", {63'd0, g}, {63'd0, id});
        @(posedge clk); #1;
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
        lat_a(n);
        chk("a_lat", 64'(n), 64'(lat));
    endtask

    task automatic reset_a();
        a_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a_rst", {57'd0, a_rsp_valid, a_req0_ready, a_req1_ready, a_rsp_id,
                      a_rsp_sign, a_rsp_err, (a_rsp_data != 32'd0)}, 64'd0);
        @(posedge clk); #1;
        a_rst_n = 1'b1;
    endtask

    task automatic drain_a();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic g;
        int   n;
        logic [34:0] e;

        {a_req0_valid, a_req1_valid, b_req0_valid, b_req1_valid} = '0;
        {a_req0_a, a_req0_b, a_req1_a, a_req1_b} = '0;
        {b_req0_a, b_req0_b, b_req1_a, b_req1_b} = '0;
        {a_req0_op, a_req1_op, b_req0_op, b_req1_op} = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #2;

        // Instance A: single-requester operations
        reset_a();
        single_a(1'b0, 32'd5, 32'hFFFF_FFF9, 5'h01, 2);
        single_a(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'h02, 2);
        single_a(1'b1, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'h05, 2);
        single_a(1'b1, 32'h1234_5678, 32'h0000_0001, 5'h1F, 1);
        single_a(1'b1, 32'h0000_00F0, 32'h0000_000F, 5'h04, 2);
        single_a(1'b0, 32'hDEAD_BEEF, 32'h1, 5'h00, 2);
        drain_a();

        // Instance A: round robin with both held valid
        reset_a();
        a_req0_a = 32'd10; a_req0_b = 32'd20; a_req0_op = 5'h01;
        a_req1_a = 32'd3;  a_req1_b = 32'd9;  a_req1_op = 5'h02;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back(model(1'b0, 32'd10, 32'd20, 5'h01));
            else            sb.push_back(model(1'b1, 32'd3, 32'd9, 5'h02));
        end
        a_req0_valid = 1'b1;
        a_req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt_a(g);
            chk("a_rr_gnt", {63'd0, g}, 64'(i % 2));
            @(posedge clk); #1;
            if (i == 3) begin
                a_req0_valid = 1'b0;
                a_req1_valid = 1'b0;
            end
        end
        drain_a();

        // Instance A: response backpressure
        reset_a();
        a_rsp_ready = 1'b0;
        a_req0_a = 32'hFF00_FF00; a_req0_b = 32'h0FF0_0FF0; a_req0_op = 5'h03;
        a_req1_a = 32'h0;         a_req1_b = 32'h0;         a_req1_op = 5'h06;
        e = model(1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'h03);
        sb.push_back(e);
        a_req0_valid = 1'b1;
        a_req1_valid = 1'b1;
        wait_gnt_a(g);
        chk("a_bp_gnt", {63'd0, g}, 64'd0);
        @(posedge clk); #1;
        lat_a(n);
        chk("a_bp_lat", 64'(n), 64'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a_bp_hold", {28'd0, a_rsp_valid, a_rsp_id, a_rsp_err, a_rsp_sign,
                              a_req0_ready, a_req1_ready, a_rsp_data},
                {28'd0, 1'b1, 1'b0, e[33], e[32], 1'b0, 1'b0, e[31:0]});
        end
        @(posedge clk); #1;
        a_rsp_ready = 1'b1;
        sb.push_back(model(1'b1, 32'h0, 32'h0, 5'h06));
        @(negedge clk);
        chk("a_bp_hs", {63'd0, a_rsp_valid}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("a_bp_one", {61'd0, a_rsp_valid, a_req1_ready, a_req0_ready}, 64'b010);
        @(posedge clk); #1;
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
        drain_a();

        // Instance B: reset state and START_PRI=1 round robin
        b_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b_rst", {60'd0, b_rsp_valid, b_req0_ready, b_req1_ready, b_rsp_err}, 64'd0);
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        b_req0_a = 32'd10; b_req0_b = 32'd20; b_req0_op = 5'h01;
        b_req1_a = 32'd3;  b_req1_b = 32'd9;  b_req1_op = 5'h02;
        b_req0_valid = 1'b1;
        b_req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt_b(g);
            chk("b_rr_gnt", {63'd0, g}, 64'((i + 1) % 2));
            $display("[TB] B grant id=%0d", g);
            @(posedge clk); #1;
            if (i == 3) begin
                b_req0_valid = 1'b0;
                b_req1_valid = 1'b0;
            end
            if (i == 0) begin
                lat_b(n);
                chk("b_lat", 64'(n), 64'd5);
                chk("b_rsp", {30'd0, b_rsp_id, b_rsp_sign, b_rsp_data},
                    {30'd0, 1'b1, 1'b1, 32'hFFFF_FFFA});
            end
        end
        repeat (8) @(posedge clk);
        #1;

        // Instance B: reset during EXEC clears everything immediately
        b_req1_a = 32'h00FF_00FF; b_req1_b = 32'h0F0F_0F0F; b_req1_op = 5'h05;
        b_req1_valid = 1'b1;
        wait_gnt_b(g);
        chk("b_pre_gnt", {63'd0, g}, 64'd1);
        @(posedge clk); #1;
        b_req1_valid = 1'b0;
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        #1;
        chk("b_mid_rst", {28'd0, b_rsp_valid, b_req0_ready, b_req1_ready, b_rsp_id,
                          b_rsp_sign, b_rsp_err, b_rsp_data}, 64'd0);
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        b_req0_valid = 1'b1;
        b_req1_valid = 1'b1;
        wait_gnt_b(g);
        chk("b_post_rst_gnt", {63'd0, g}, 64'd1);
        @(posedge clk); #1;
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
        repeat (8) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lab02_alu_arb.md
Name: lab02_alu_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the lab02 ALU; one lab02_alu instance is shared between two independent requesters.
- Accepts one operation at a time through a valid/ready handshake and drives the ALU operands and opcode for a fixed execute window.
- Captures the result and sign into registers and returns them on a single shared response channel tagged with the requester id.

Parameters:
- EXEC_CYCLES, 1, cycles operands are held on the ALU before capture; legal range 1..15.
- START_PRI, 0, requester preferred after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_a  input  32  operand A, signed.
- req0_b  input  32  operand B, signed.
- req0_op  input  5  ALU opcode.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req1_valid, req1_a, req1_b, req1_op, req1_ready  same as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_data  output  32  result.
- rsp_sign  output  1  sign of the ADD/SUB result.
- rsp_err  output  1  opcode was illegal.

Behaviour:
- Opcodes: NOP=0x00, ADD=0x01, SUB=0x02, AND=0x03, OR=0x04, XOR=0x05, NOR=0x06. Values 0x07..0x1F are illegal.
- Reset (asynchronous, on rst_n low, including mid-operation):
  - state goes to IDLE; priority pointer loads START_PRI; the execute counter clears.
  - All outputs and result registers go to 0; the ALU opcode is driven to NOP.
- IDLE state:
  - req*_ready is combinational: 1 only in IDLE, only for the granted requester.
  - Grant rule: if exactly one valid, grant it. If both are valid, grant the one selected by the priority pointer.
  - On grant, latch a, b, op and id; set the priority pointer to the other requester.
  - Legal op -> EXEC. Illegal op -> RESP directly.
- EXEC state:
  - Latched operands and op drive the ALU; the counter runs 0..EXEC_CYCLES-1.
  - On the last count, capture the result into registers and go to RESP.
  - ADD/SUB: rsp_data = low 32 bits; rsp_sign = bit 32 of the 33-bit sum/difference of the sign-extended operands. This is the true result sign, not affected by 32-bit overflow.
  - AND/OR/XOR/NOR: rsp_data = ALU output; rsp_sign = 0.
  - NOP: rsp_data = 0; rsp_sign = 0. The ALU's held value is never returned.
- RESP state:
  - rsp_valid = 1; rsp_id, rsp_data, rsp_sign and rsp_err stay stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE; rsp_valid drops the next cycle.
- Illegal op: rsp_err = 1, rsp_data = 0, rsp_sign = 0. rsp_err clears when the next operation is granted.
- Latency:
  - Legal op: grant at cycle T, rsp_valid at T+1+EXEC_CYCLES.
  - Illegal op: rsp_valid at T+1.
  - Next grant is no earlier than the cycle after the response handshake.
- Requester-side changes to a/b/op while not ready have no effect. A valid that drops before grant is simply lost; no error is flagged.
- Priority only changes on a grant. A lone requester can be granted back-to-back.

Decomposition:
- Shared package lab02_pkg:
  - Opcode constants A_NOP..A_NOR, plus A_LAST=0x06 for the legality check.
  - Data width 32, opcode width 5.
  - State encoding IDLE/EXEC/RESP.
- Sub-module: the existing lab02_alu, instantiated once; this block owns only control, arbitration and result registers.

Test Plan:
- Only req0, ADD, a=5, b=-7 (0xFFFFFFF9), EXEC_CYCLES=1 -> req0_ready at T; rsp_valid at T+2; rsp_id=0, rsp_data=0xFFFFFFFE, rsp_sign=1, rsp_err=0.
- SUB, a=0x7FFFFFFF, b=0xFFFFFFFF -> rsp_data=0x80000000, rsp_sign=0. XOR, a=0xF0F0F0F0, b=0xFFFF0000 -> rsp_data=0x0F0FF0F0, rsp_sign=0.
- req0 and req1 held valid continuously with START_PRI=0, rsp_ready=1 -> grants and rsp_id sequence 0,1,0,1. With START_PRI=1 -> sequence 1,0,1,0.
- req1 op=0x1F -> rsp_valid one cycle after grant; rsp_err=1, rsp_data=0, no EXEC cycles. Next legal op -> rsp_err=0.
- rsp_ready low for 10 cycles with both requesters valid -> response fields constant, req0_ready=req1_ready=0. Raise rsp_ready -> exactly one handshake, then a new grant.
- EXEC_CYCLES=4, rst_n pulsed low during EXEC -> all outputs 0 immediately. After release, both valid -> the START_PRI requester is granted first.
